io_responder: RTL and testbench

- Responder end of the core's IO memory interface: a single-cycle IO address/data/write-strobe bus with no read strobe.
- Decodes one-hot IO word addresses and implements three registers: an LED register, a UART transmit-data port backed by a FIFO, and a UART status/control register.
- Drives the board LEDs and an 8N1 UART TX line.
- Sits in the SOC beside the core and replaces the ad-hoc LED/`$write` decode there.

---
 rtl/io_responder_pkg.sv | 28 ++
 rtl/uart_tx_ser.sv | 87 ++++++++
 rtl/io_responder.sv | 134 +++++++++++++
 tb/tb_io_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// IO map shared by the core, the SOC and io_responder: address decode bits,
// status-register layout and serializer state encodings.
package io_responder_pkg;

  // Address bit that selects IO space, and the bit holding word index 0.
  localparam int IO_SPACE_BIT = 22;
  localparam int WORD_LSB     = 2;

  // Word-address one-hot indices (relative to WORD_LSB).
  localparam int LEDS      = 0;
  localparam int UART_DATA = 1;
  localparam int UART_STAT = 2;
  localparam int NUM_REGS  = 3;

  // UART_STAT layout; writing 1 to the OVF position clears the sticky flag.
  localparam int STAT_FULL    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 transmit serializer: accepts one byte when idle (valid/ready) and shifts
// it out LSB first with a start and stop bit, CLKS_PER_BIT clocks per bit.
module uart_tx_ser
  import io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  ser_state_t    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;

  assign bit_end  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign in_ready = (state == SER_IDLE);
  assign busy     = (state != SER_IDLE);

  // txd is loaded one edge ahead of each bit so the line changes exactly
  // when the state does.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= SER_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        SER_IDLE: begin
          baud_cnt <= '0;
          txd      <= 1'b1;
          if (in_valid) begin
            shift   <= in_data;
            bit_idx <= '0;
            txd     <= 1'b0;
            state   <= SER_START;
          end
        end
        SER_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= shift[0];
            state    <= SER_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        SER_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= SER_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        SER_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= SER_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// IO responder: one-hot register decode for LEDs, UART TX data (via FIFO) and
// UART status/control, driving the board LEDs and the serial TX line.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 16,
  parameter int LED_W        = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      io_addr,
  input  logic [31:0]      io_wdata,
  input  logic             io_wr,
  output logic [31:0]      io_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_txd
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_REGS-1:0] sel;
  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                ovf;
  logic                ovf_set;
  logic                ovf_clr;
  logic                ser_ready;
  logic                ser_busy;
  logic                busy;
  logic [31:0]         stat_word;
  logic                unused_io;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign sel[gi] = io_addr[IO_SPACE_BIT] & io_addr[WORD_LSB + gi];
    end
  endgenerate

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = io_wr & sel[UART_DATA];
  assign push     = push_req & ~full;
  assign pop      = ser_ready & ~empty;
  assign ovf_set  = push_req & full;
  assign ovf_clr  = io_wr & sel[UART_STAT] & io_wdata[STAT_OVF];
  assign busy     = ~empty | ser_busy;

  // Only a subset of address/data bits is decoded.
  assign unused_io = ^{io_addr, io_wdata};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A set in the same cycle as a clear wins, so no overflow is ever lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf  <= 1'b0;
      leds <= '0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (io_wr && sel[LEDS]) begin
        leds <= io_wdata[LED_W-1:0];
      end
    end
  end

  always_comb begin
    stat_word                          = '0;
    stat_word[STAT_FULL]               = full;
    stat_word[STAT_BUSY]               = busy;
    stat_word[STAT_OVF]                = ovf;
    stat_word[STAT_CNT_LSB +: CNT_W]   = count;
  end

  // Multiple selected registers read back as the OR of their values.
  always_comb begin
    io_rdata = '0;
    if (sel[LEDS]) begin
      io_rdata = io_rdata | 32'(leds);
    end
    if (sel[UART_STAT]) begin
      io_rdata = io_rdata | stat_word;
    end
  end

  uart_tx_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (~empty),
    .in_data  (fifo_mem[rd_ptr]),
    .in_ready (ser_ready),
    .txd      (uart_txd),
    .busy     (ser_busy)
  );

endmodule

// File: tb/tb_io_responder.sv
// Randomized scoreboard bench for io_responder with a timeline-based reference
// model of the FIFO, serializer frames and registers.
module tb_io_responder;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 6;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   io_addr = '0;
  logic [31:0]   io_wdata = '0;
  logic          io_wr = 1'b0;
  logic [31:0]   io_rdata;
  logic [LW-1:0] leds;
  logic          uart_txd;

  io_responder #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .LED_W       (LW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rdata (io_rdata),
    .leds     (leds),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: every accepted byte with the cycle it was written and
  // the cycle the serializer takes it; everything else is derived from these.
  int            push_c[$];
  int            pop_c[$];
  logic [7:0]    byte_q[$];
  logic [LW-1:0] m_leds = '0;
  bit            m_ovf = 1'b0;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;
  frame_t exp_frames[$];

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   rdata;
    logic [LW-1:0] leds;
    logic          txd;
    int            at;
  } rd_t;
  rd_t exp_rd[$];

  function automatic int m_count(int t);
    int n = 0;
    foreach (push_c[i]) begin
      if (push_c[i] + 1 <= t) n++;
      if (pop_c[i] + 1 <= t) n--;
    end
    return n;
  endfunction

  function automatic bit m_busy(int t);
    if (m_count(t) > 0) return 1'b1;
    foreach (pop_c[i]) begin
      if (pop_c[i] + 1 <= t && t <= pop_c[i] + FRAME) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic m_txd(int t);
    int s;
    int k;
    foreach (pop_c[i]) begin
      s = pop_c[i] + 1;
      if (t >= s && t < s + FRAME) begin
        k = (t - s) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return byte_q[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a, int t);
    logic [31:0] r = '0;
    int cnt;
    if (a[22]) begin
      cnt = m_count(t);
      if (a[2]) r = r | 32'(m_leds);
      if (a[4]) r = r | {19'h0, 5'(cnt), 5'h0, m_ovf, m_busy(t), (cnt == DEPTH)};
    end
    return r;
  endfunction

  function automatic void m_write(logic [31:0] a, logic [31:0] d, int c);
    bit set = 1'b0;
    int p;
    if (!a[22]) return;
    if (a[2]) m_leds = d[LW-1:0];
    if (a[3]) begin
      if (m_count(c) == DEPTH) begin
        set = 1'b1;
      end else begin
        p = c + 1;
        if (pop_c.size() > 0 && pop_c[$] + FRAME + 1 > p) p = pop_c[$] + FRAME + 1;
        push_c.push_back(c);
        pop_c.push_back(p);
        byte_q.push_back(d[7:0]);
        exp_frames.push_back('{d[7:0], p + 1});
      end
    end
    if (set) m_ovf = 1'b1;
    else if (a[4] && d[2]) m_ovf = 1'b0;
  endfunction

  // One bus cycle; a read request queues the expected response for the monitor.
  task automatic op(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rd);
    @(posedge clk);
    #1;
    io_addr  = a;
    io_wdata = d;
    io_wr    = wr;
    if (rd) exp_rd.push_back('{a, m_read(a, cycle), m_leds, m_txd(cycle), cycle});
    if (wr) m_write(a, d, cycle);
  endtask

  task automatic idle(input int n);
    repeat (n) op(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    resetn  = 1'b0;
    io_wr   = 1'b0;
    io_addr = '0;
    push_c.delete();
    pop_c.delete();
    byte_q.delete();
    exp_frames.delete();
    m_leds = '0;
    m_ovf  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Register-read monitor.
  rd_t r;
  always @(negedge clk) begin
    while (exp_rd.size() > 0 && exp_rd[0].at <= cycle) begin
      r = exp_rd.pop_front();
      checks++;
      if (r.at != cycle || io_rdata !== r.rdata || leds !== r.leds || uart_txd !== r.txd) begin
        errors++;
        $display("FAIL read addr=%h cycle %0d: got rdata=%h leds=%h txd=%b, required rdata=%h leds=%h txd=%b (at %0d)",
                 r.addr, cycle, io_rdata, leds, uart_txd, r.rdata, r.leds, r.txd, r.at);
      end
    end
  end

  // UART line monitor: decodes frames at mid-bit and compares byte and start cycle.
  bit         mon_on = 1'b0;
  int         mon_cyc = 0;
  int         mon_start = 0;
  logic [9:0] mon_bits;
  frame_t     e;
  always @(negedge clk) begin
    if (!resetn) begin
      mon_on = 1'b0;
    end else if (!mon_on && uart_txd === 1'b0) begin
      mon_on    = 1'b1;
      mon_cyc   = 0;
      mon_start = cycle;
    end
    if (mon_on && resetn) begin
      if (mon_cyc % CPB == CPB / 2) mon_bits[mon_cyc / CPB] = uart_txd;
      if (mon_cyc == 9 * CPB + CPB / 2) begin
        mon_on = 1'b0;
        checks++;
        if (exp_frames.size() == 0) begin
          errors++;
          $display("FAIL frame: got byte %h starting cycle %0d, required no frame", mon_bits[8:1], mon_start);
        end else begin
          e = exp_frames.pop_front();
          if (mon_bits !== {1'b1, e.b, 1'b0}) begin
            errors++;
            $display("FAIL frame bits: got %b, required %b", mon_bits, {1'b1, e.b, 1'b0});
          end
          checks++;
          if (mon_start != e.start) begin
            errors++;
            $display("FAIL frame start: byte %h got cycle %0d, required %0d", e.b, mon_start, e.start);
          end
        end
      end else begin
        mon_cyc++;
      end
    end
  end

  initial begin
    int c0;
    int kind;
    logic [31:0] a;
    logic [31:0] d;

    do_reset(3);
    op(32'h0040_0004, 0, 0, 1);
    op(32'h0040_0010, 0, 0, 1);
    op(32'h0040_001C, 0, 0, 1);
    op(32'h0000_0010, 0, 0, 1);

    // LED register and out-of-space read
    op(32'h0040_0004, 32'h0000_002A, 1, 0);
    op(32'h0040_0004, 0, 0, 1);
    op(32'h0000_0004, 0, 0, 1);

    // Single byte: busy sampled every cycle of the frame and just after
    op(32'h0040_0008, 32'h0000_0055, 1, 0);
    repeat (FRAME + 3) op(32'h0040_0010, 0, 0, 1);

    // Overflow burst, then clear ovf
    for (int i = 1; i <= 18; i++) op(32'h0040_0008, 32'(i), 1, 0);
    op(32'h0040_0010, 0, 0, 1);
    op(32'h0040_0010, 32'h0000_0004, 1, 0);
    op(32'h0040_0010, 0, 0, 1);
    for (int i = 0; i < 2000 && exp_frames.size() > 0; i++) idle(1);
    idle(4);

    // Combined LED + data write
    op(32'h0040_000C, 32'h0000_0041, 1, 0);
    op(32'h0040_000C, 0, 0, 1);
    op(32'h0040_0010, 0, 0, 1);
    for (int i = 0; i < 200 && exp_frames.size() > 0; i++) idle(1);
    idle(4);

    // Reset mid-DATA with three bytes queued
    c0 = cycle + 1;
    for (int i = 0; i < 4; i++) op(32'h0040_0008, 32'hA0 + 32'(i), 1, 0);
    op(32'h0040_0004, 32'h0000_0015, 1, 0);
    while (cycle < c0 + 13) idle(1);
    op(32'h0040_0010, 0, 0, 1);
    do_reset(1);
    op(32'h0040_0010, 0, 0, 1);
    op(32'h0040_0004, 0, 0, 1);
    repeat (60) op(32'h0000_0000, 0, 0, 1);

    // Randomized traffic, including multi-select addresses and rare resets
    repeat (700) begin
      kind = $urandom_range(0, 19);
      a = {9'h0, 1'($urandom_range(0, 7) != 0), 17'h0, 3'($urandom_range(1, 7)), 2'b00};
      d = $urandom;
      if (kind < 6) op(32'h0040_0008, d, 1, 0);
      else if (kind < 9) op(a, d, 1, 0);
      else if (kind < 15) op(a, 0, 0, 1);
      else if (kind < 19) idle(1);
      else if ($urandom_range(0, 9) == 0) do_reset(1);
      else op(32'h0040_0010, 32'h0000_0004, 1, 0);
    end

    for (int i = 0; i < 3000 && exp_frames.size() > 0; i++) idle(1);
    idle(4);
    checks++;
    if (exp_frames.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames and %0d reads outstanding, required 0 and 0",
               exp_frames.size(), exp_rd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cycle);
    $fatal(1, "watchdog");
  end

endmodule
